pc_sequencer: RTL and testbench

Controller that sequences the instruction-fetch stage: owns the program counter and drives the fetch stage's `newPC` input every cycle. It handles boot hold-off, sequential advance, stall, branch/jump redirect with bubble flushing, halt, and address-fault detection. It sits between the hazard/branch logic (ID/EX) and the fetch stage, which latches `newPC` on each rising edge.

---
 rtl/pc_sequencer_pkg.sv | 24 ++
 rtl/pc_addr_check.sv | 11 +
 rtl/pc_sequencer.sv | 144 ++++++++++++++
 tb/tb_pc_sequencer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer: state encodings, memory size and reset PC.
// Imported by pc_sequencer and pc_addr_check.
package pc_sequencer_pkg;

  localparam int          IMEM_SIZE        = 256;  // instruction memory depth in words
  localparam logic [31:0] IMEM_LIMIT       = 32'(IMEM_SIZE * 4);
  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;
  localparam int          CNT_W            = 16;

  typedef enum logic [1:0] {
    PCS_BOOT  = 2'd0,
    PCS_RUN   = 2'd1,
    PCS_FLUSH = 2'd2,
    PCS_HALT  = 2'd3
  } pcs_state_e;

  // Sequential successor; reaching the top of instruction memory wraps to 0.
  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    logic [31:0] sum;
    sum = pc + 32'd4;
    return (sum >= IMEM_LIMIT) ? 32'd0 : sum;
  endfunction

endpackage

// File: rtl/pc_addr_check.sv
// Combinational redirect-target check: word aligned and inside instruction memory.
module pc_addr_check
  import pc_sequencer_pkg::*;
(
  input  logic [31:0] addr,
  output logic        ok
);

  assign ok = (addr[1:0] == 2'b00) && (addr < IMEM_LIMIT);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: boot hold-off, advance, stall, redirect with bubbles, halt, fault.
// Optional exception redirect (exc_req/exc_vec/epc) is built when PC_SEQ_EXC_EN is defined.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = PC_RESET_DEFAULT,
  parameter int          BOOT_CYCLES  = 2,
  parameter int          FLUSH_CYCLES = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jmp,
  input  logic [31:0] jmp_target,
  input  logic        halt_req,
`ifdef PC_SEQ_EXC_EN
  input  logic        exc_req,
  input  logic [31:0] exc_vec,
  output logic [31:0] epc,
`endif
  output logic [31:0] newPC,
  output logic        fetch_valid,
  output logic        flush,
  output logic        halted,
  output logic        fault
);

  pcs_state_e         state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n, cnt_inc;
  logic [31:0]        pc_n;
  logic               flush_n, fault_n;
  logic               redir;
  logic [31:0]        redir_target;
  logic               target_ok;
`ifdef PC_SEQ_EXC_EN
  logic [31:0]        epc_n;
  logic               exc_sel;
`endif

  // Redirect source priority: exception, then branch (older), then jump.
  always_comb begin
    redir        = 1'b0;
    redir_target = br_target;
`ifdef PC_SEQ_EXC_EN
    exc_sel      = 1'b0;
    if (exc_req) begin
      redir        = 1'b1;
      redir_target = exc_vec;
      exc_sel      = 1'b1;
    end else
`endif
    if (br_taken) begin
      redir        = 1'b1;
      redir_target = br_target;
    end else if (jmp) begin
      redir        = 1'b1;
      redir_target = jmp_target;
    end
  end

  pc_addr_check u_addr_check (
    .addr (redir_target),
    .ok   (target_ok)
  );

  assign cnt_inc = cnt + CNT_W'(1);

  // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pc_n    = newPC;
    flush_n = 1'b0;
    fault_n = fault;
`ifdef PC_SEQ_EXC_EN
    epc_n   = epc;
`endif
    unique case (state)
      PCS_BOOT: begin
        if (32'(cnt_inc) >= 32'(BOOT_CYCLES)) begin
          state_n = PCS_RUN;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      PCS_RUN, PCS_FLUSH: begin
        if (redir) begin
          if (target_ok) begin
            pc_n    = redir_target;
            flush_n = 1'b1;
            cnt_n   = '0;
            state_n = (FLUSH_CYCLES > 0) ? PCS_FLUSH : PCS_RUN;
`ifdef PC_SEQ_EXC_EN
            if (exc_sel) epc_n = newPC;
`endif
          end else begin
            fault_n = 1'b1;
            state_n = PCS_HALT;
          end
        end else if (state == PCS_RUN) begin
          if (halt_req)   state_n = PCS_HALT;
          else if (!stall) pc_n   = pc_inc(newPC);
        end else if (32'(cnt_inc) >= 32'(FLUSH_CYCLES)) begin
          state_n = PCS_RUN;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      PCS_HALT: ;
      default: state_n = PCS_BOOT;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= PCS_BOOT;
      cnt   <= '0;
      newPC <= RESET_PC;
      flush <= 1'b0;
      fault <= 1'b0;
`ifdef PC_SEQ_EXC_EN
      epc   <= 32'd0;
`endif
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      newPC <= pc_n;
      flush <= flush_n;
      fault <= fault_n;
`ifdef PC_SEQ_EXC_EN
      epc   <= epc_n;
`endif
    end
  end

  assign fetch_valid = (state == PCS_RUN);
  assign halted      = (state == PCS_HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized run against a reference model.
module tb_pc_sequencer;
  import pc_sequencer_pkg::*;

  localparam int          BOOT  = 2;
  localparam int          FLUSHC = 1;
  localparam logic [31:0] RPC   = 32'h0;
  localparam longint      LIMIT = longint'(IMEM_SIZE) * 4;

  logic        CLK = 1'b0;
  logic        RST, stall, br_taken, jmp, halt_req;
  logic [31:0] br_target, jmp_target;
  logic [31:0] newPC;
  logic        fetch_valid, flush, halted, fault;
`ifdef PC_SEQ_EXC_EN
  logic        exc_req;
  logic [31:0] exc_vec, epc;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  pc_sequencer #(.RESET_PC(RPC), .BOOT_CYCLES(BOOT), .FLUSH_CYCLES(FLUSHC)) dut (
    .CLK(CLK), .RST(RST), .stall(stall), .br_taken(br_taken), .br_target(br_target),
    .jmp(jmp), .jmp_target(jmp_target), .halt_req(halt_req),
`ifdef PC_SEQ_EXC_EN
    .exc_req(exc_req), .exc_vec(exc_vec), .epc(epc),
`endif
    .newPC(newPC), .fetch_valid(fetch_valid), .flush(flush), .halted(halted), .fault(fault)
  );

  // Reference model: phase plus a count of remaining boot/bubble cycles.
  typedef enum {M_BOOT, M_RUN, M_BUBBLE, M_STOPPED} mphase_e;
  mphase_e     m_phase;
  int          m_left;
  logic [31:0] m_pc, m_epc;
  logic        m_flush, m_fault;

  function automatic bit target_good(input logic [31:0] t);
    return (t % 4 == 0) && (longint'(t) < LIMIT);
  endfunction

  task automatic model_step();
    logic        have;
    logic        is_exc;
    logic [31:0] tgt;
    if (RST) begin
      m_phase = M_BOOT; m_left = BOOT; m_pc = RPC; m_epc = 0; m_flush = 0; m_fault = 0;
      return;
    end
    m_flush = 0;
    have = 0; is_exc = 0; tgt = 0;
`ifdef PC_SEQ_EXC_EN
    if (exc_req) begin have = 1; is_exc = 1; tgt = exc_vec; end else
`endif
    if (br_taken) begin have = 1; tgt = br_target; end
    else if (jmp) begin have = 1; tgt = jmp_target; end
    case (m_phase)
      M_BOOT: begin
        m_left = m_left - 1;
        if (m_left <= 0) m_phase = M_RUN;
      end
      M_RUN, M_BUBBLE: begin
        if (have) begin
          if (target_good(tgt)) begin
            if (is_exc) m_epc = m_pc;
            m_pc = tgt; m_flush = 1; m_left = FLUSHC;
            m_phase = (FLUSHC > 0) ? M_BUBBLE : M_RUN;
          end else begin
            m_fault = 1; m_phase = M_STOPPED;
          end
        end else if (m_phase == M_RUN) begin
          if (halt_req) m_phase = M_STOPPED;
          else if (!stall) m_pc = (longint'(m_pc) + 4 >= LIMIT) ? 32'd0 : m_pc + 4;
        end else begin
          m_left = m_left - 1;
          if (m_left <= 0) m_phase = M_RUN;
        end
      end
      default: ;
    endcase
  endtask

  task automatic idle();
    RST = 0; stall = 0; br_taken = 0; jmp = 0; halt_req = 0; br_target = 0; jmp_target = 0;
`ifdef PC_SEQ_EXC_EN
    exc_req = 0; exc_vec = 0;
`endif
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [31:0] pc, input logic fv, input logic fl,
                            input logic hl, input logic ft);
    // plain comparison bundle used only by the directed scenarios below
    checks++;
    if (newPC !== pc || fetch_valid !== fv || flush !== fl || halted !== hl || fault !== ft) begin
      failures++;
      $display("FAIL %s: got pc=%h fv=%b flush=%b halted=%b fault=%b, want pc=%h fv=%b flush=%b halted=%b fault=%b",
               name, newPC, fetch_valid, flush, halted, fault, pc, fv, fl, hl, ft);
    end
  endtask

  task automatic do_reset();
    idle(); RST = 1; step(); step(); RST = 0;
  endtask

  task automatic test_reset();
    idle(); RST = 1; step();
    expect_out("reset_values", RPC, 0, 0, 0, 0);
    RST = 0;
    step(); expect_out("boot_cycle1", 32'h0, 0, 0, 0, 0);
    step(); expect_out("boot_done_pc0", 32'h0, 1, 0, 0, 0);
    step(); expect_out("seq_pc4", 32'h4, 1, 0, 0, 0);
    step(); expect_out("seq_pc8", 32'h8, 1, 0, 0, 0);
    step(); expect_out("seq_pcC", 32'hC, 1, 0, 0, 0);
    step(); expect_out("seq_pc10", 32'h10, 1, 0, 0, 0);
  endtask

  task automatic test_redirect_priority();
    br_taken = 1; br_target = 32'h40; jmp = 1; jmp_target = 32'h80; stall = 1;
    step(); expect_out("br_beats_jmp_stall", 32'h40, 0, 1, 0, 0);
    idle();
    step(); expect_out("flush_done", 32'h40, 1, 0, 0, 0);
    step(); expect_out("after_target", 32'h44, 1, 0, 0, 0);
  endtask

  task automatic test_stall();
    jmp = 1; jmp_target = 32'h20;
    step(); idle();
    step(); expect_out("at_0x20", 32'h20, 1, 0, 0, 0);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      step(); expect_out($sformatf("stall_hold%0d", i), 32'h20, 1, 0, 0, 0);
    end
    stall = 0;
    step(); expect_out("stall_release", 32'h24, 1, 0, 0, 0);
  endtask

  task automatic test_fault_misaligned();
    jmp = 1; jmp_target = 32'h42;
    step(); expect_out("misaligned_fault", 32'h24, 0, 0, 1, 1);
    br_taken = 1; br_target = 32'h8; halt_req = 1; jmp = 0;
    for (int i = 0; i < 4; i++) step();
    expect_out("halt_frozen", 32'h24, 0, 0, 1, 1);
    idle(); RST = 1;
    step(); expect_out("halt_reset", RPC, 0, 0, 0, 0);
    RST = 0;
  endtask

  task automatic test_fault_range();
    step(); step(); step();
    expect_out("range_run", 32'h4, 1, 0, 0, 0);
    br_taken = 1; br_target = IMEM_LIMIT;
    step(); expect_out("range_fault", 32'h4, 0, 0, 1, 1);
    idle(); step(); step();
    expect_out("range_frozen", 32'h4, 0, 0, 1, 1);
    RST = 1;
    step(); expect_out("range_reset", RPC, 0, 0, 0, 0);
    RST = 0;
  endtask

  task automatic test_wrap();
    step(); step();
    jmp = 1; jmp_target = IMEM_LIMIT - 32'd8;
    step(); idle();
    step(); expect_out("wrap_at_m8", IMEM_LIMIT - 32'd8, 1, 0, 0, 0);
    step(); expect_out("wrap_at_m4", IMEM_LIMIT - 32'd4, 1, 0, 0, 0);
    step(); expect_out("wrap_to_0", 32'h0, 1, 0, 0, 0);
  endtask

`ifdef PC_SEQ_EXC_EN
  task automatic test_exc();
    do_reset(); step(); step();
    jmp = 1; jmp_target = 32'h30;
    step(); idle(); step();
    exc_req = 1; exc_vec = 32'h80; br_taken = 1; br_target = 32'h40;
    step();
    expect_out("exc_redirect", 32'h80, 0, 1, 0, 0);
    checks++;
    if (epc !== 32'h30) begin
      failures++; $display("FAIL exc_epc: got %h want %h", epc, 32'h30);
    end
    idle();
  endtask
`endif

  task automatic test_random();
    int halted_for;
    idle(); RST = 1;
    @(posedge CLK); model_step(); #1;
    RST = 0;
    halted_for = 0;
    for (int i = 0; i < 3000; i++) begin
      stall    = ($urandom_range(99) < 25);
      br_taken = ($urandom_range(99) < 10);
      jmp      = ($urandom_range(99) < 10);
      halt_req = ($urandom_range(99) < 2);
      br_target  = ($urandom_range(7) == 0) ? $urandom() : 32'($urandom_range(IMEM_SIZE - 1)) << 2;
      jmp_target = ($urandom_range(7) == 0) ? $urandom() : 32'($urandom_range(IMEM_SIZE - 1)) << 2;
`ifdef PC_SEQ_EXC_EN
      exc_req = ($urandom_range(99) < 4);
      exc_vec = ($urandom_range(7) == 0) ? $urandom() : 32'($urandom_range(IMEM_SIZE - 1)) << 2;
`endif
      RST = ($urandom_range(99) < 1) || (halted_for > 15);
      @(posedge CLK); model_step(); #1;
      halted_for = (m_phase == M_STOPPED) ? halted_for + 1 : 0;
      checks++;
      if (newPC !== m_pc || fetch_valid !== (m_phase == M_RUN) || flush !== m_flush ||
          halted !== (m_phase == M_STOPPED) || fault !== m_fault) begin
        failures++;
        $display("FAIL random_cycle%0d: got pc=%h fv=%b flush=%b halted=%b fault=%b, want pc=%h fv=%b flush=%b halted=%b fault=%b",
                 i, newPC, fetch_valid, flush, halted, fault, m_pc, (m_phase == M_RUN), m_flush,
                 (m_phase == M_STOPPED), m_fault);
      end
`ifdef PC_SEQ_EXC_EN
      checks++;
      if (epc !== m_epc) begin
        failures++; $display("FAIL random_epc%0d: got %h want %h", i, epc, m_epc);
      end
`endif
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_redirect_priority();
    test_stall();
    test_fault_misaligned();
    test_fault_range();
    test_wrap();
`ifdef PC_SEQ_EXC_EN
    test_exc();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
